// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer: FSM encoding and default byte width.
package uart_pkg;
  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;
endpackage

// File: rtl/uart_tx_buffer_if.sv
// Producer / UART-side signal bundle for uart_tx_buffer.
interface uart_tx_buffer_if
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
);
  logic                     wr_en;
  logic [DATA_W-1:0]        wr_data;
  logic                     o_full;
  logic                     o_empty;
  logic [$clog2(DEPTH):0]   o_count;
  logic                     o_overflow;
  logic                     o_start;
  logic [DATA_W-1:0]        o_tx_data;
  logic                     i_tx_done;

  modport master (
    output wr_en, wr_data, i_tx_done,
    input  o_full, o_empty, o_count, o_overflow, o_start, o_tx_data
  );

  modport slave (
    input  wr_en, wr_data, i_tx_done,
    output o_full, o_empty, o_count, o_overflow, o_start, o_tx_data
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Circular FIFO: storage, wrapping pointers, entry count, full/empty flags and overflow pulse.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow
);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_pop, do_push;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // a full FIFO still accepts a push when a pop frees a slot in the same cycle
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      overflow <= push & full & ~do_pop;
    end
  end
endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO in front of a UART transmitter: pops one byte, pulses start, waits for the
// rising edge of tx_done, repeats.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_buffer_if.slave bus
);
  tx_state_e         state, state_nxt;
  logic              done_q, done_rise;
  logic              pop;
  logic [DATA_W-1:0] fifo_data;
  logic [DATA_W-1:0] tx_q;
  logic              start_q;

  uart_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (bus.o_full),
    .empty     (bus.o_empty),
    .count     (bus.o_count),
    .overflow  (bus.o_overflow)
  );

  assign done_rise = bus.i_tx_done & ~done_q;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!bus.o_empty) begin
        pop       = 1'b1;
        state_nxt = START;
      end
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_rise) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // start is registered off START, so it appears two edges after the push is sampled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      tx_q    <= '0;
    end else begin
      state   <= state_nxt;
      done_q  <= bus.i_tx_done;
      start_q <= (state == START);
      if (pop) tx_q <= fifo_data;
    end
  end

  assign bus.o_start   = start_q;
  assign bus.o_tx_data = tx_q;
endmodule
